mem_seq: RTL and testbench
==========================

# mem_seq

Parametrised memory-access sequencer for the CCSS multi-core processor. It drives the per-core address-register read enables, data-register write enables, data-register read enables and the shared data-memory write strobe for three transfer modes: broadcast load (comm), per-core load (diff) and per-core store. Compared with the fixed 4-core sequencer, it adds:
- a core count parameter and a read-latency parameter;
- a start/busy/done handshake;
- synchronous reset;
- core-count clamping.

It sits between the processor control unit and the AR/DR/D register banks plus data memory.

## Interface
Parameters:
- NUM_CORES, 4, number of cores; legal range 1..16.
- RD_LAT, 2, data-memory read latency in cycles; legal range 1..15. Each load slot lasts RD_LAT+1 cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  2  0=none, 1=comm, 2=diff, 3=store; latched with start.
- noc  in  16  number of active cores (unsigned); latched with start.
- ar_read_en  out  NUM_CORES  address register i drives memory address.
- dr_wrt_en  out  NUM_CORES  data register i captures memory read data.
- d_read_en  out  NUM_CORES  data register i drives memory write data.
- dmem_write  out  1  data-memory write strobe.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse marking the final cycle of a sequence.

## Operation
- States: IDLE, COMM, DIFF, STORE, NULL.
- All outputs are Moore-decoded from state, core index `idx` and phase counter `ph`.
- In IDLE, all outputs are 0.
- Accepted start: IDLE, start=1 and mode≠0.
  - Latch mode.
  - Latch noc_eff = min(noc, NUM_CORES).
  - Set idx=0 and ph=0.
  - If noc_eff=0, go to NULL. Otherwise go to the state for the latched mode.
- start with mode=0 is ignored. start outside IDLE is ignored.
- After latching, changes on mode or noc have no effect until the next accepted start.
- NULL lasts one cycle with busy=1, done=1 and no strobes, then returns to IDLE.
- COMM:
  - ar_read_en[0]=1 for RD_LAT+1 cycles (ph 0..RD_LAT).
  - On ph=RD_LAT, dr_wrt_en[i]=1 for every i<noc_eff, and done=1.
  - Then return to IDLE.
- DIFF: for each idx from 0 to noc_eff-1:
  - ar_read_en[idx]=1 for ph 0..RD_LAT.
  - dr_wrt_en[idx]=1 on ph=RD_LAT.
  - At ph=RD_LAT: if idx=noc_eff-1, assert done and return to IDLE; otherwise increment idx and clear ph.
- STORE: one cycle per core, for idx 0..noc_eff-1.
  - ar_read_en[idx]=1, d_read_en[idx]=1, dmem_write=1.
  - done=1 on idx=noc_eff-1, then return to IDLE.
- busy=1 in every non-IDLE state.
- Any strobe vector has at most one bit set, except dr_wrt_en in the final COMM cycle.

## Timing
- Accept edge t → first active cycle is t+1.
- Sequence lengths:
  - COMM: RD_LAT+1 cycles.
  - DIFF: noc_eff·(RD_LAT+1) cycles.
  - STORE: noc_eff cycles.
  - NULL: 1 cycle.
- done coincides with the last active cycle. The FSM is in IDLE the next cycle.
- A start held high through the done cycle is sampled in that following IDLE cycle, so there is at least one idle cycle between sequences.
- Reset:
  - rst=1 at edge t forces IDLE, idx=0, ph=0 and latched regs to 0.
  - All outputs are 0 from t+1. This applies mid-sequence as well.
  - No partial done is emitted.
- rst and start at the same edge: rst wins.
- Counter widths:
  - idx: $clog2(NUM_CORES), minimum 1 bit.
  - ph: $clog2(RD_LAT+1).
- The noc comparison is a full 16-bit unsigned compare before clamping.

## Structure
- Package mem_seq_pkg holds:
  - mode constants MODE_NONE/COMM/DIFF/STORE (2-bit);
  - state encoding constants;
  - NUM_CORES_MAX=16.
- Single module, no sub-module. The one-hot idx decode (idx → NUM_CORES-bit vector) is a local function in the package.

## Test plan
All cases use NUM_CORES=4, RD_LAT=2.
- **COMM, noc=4:** start at t → cycles t+1..t+3 ar_read_en=0001; t+3 dr_wrt_en=1111 and done=1; busy=1 over t+1..t+3; t+4 all 0.
- **DIFF, noc=2:**
  - ar_read_en=0001 for 3 cycles, with dr_wrt_en=0001 on the 3rd.
  - Then ar_read_en=0010 for 3 cycles, with dr_wrt_en=0010 and done on the 6th.
  - noc switched to 4 mid-sequence → no change.
- **STORE, noc=3:** 3 cycles of ar_read_en=d_read_en=0001,0010,0100 with dmem_write=1; done on the 3rd.
- **Boundary noc values:**
  - noc=0, mode=2 → one cycle busy=1, done=1, no strobes.
  - noc=9, mode=3 → clamps to 4, giving 4 store cycles ending at core 3.
  - mode=0 with start=1 → busy stays 0.
- **Reset and busy handling:**
  - rst at the 4th DIFF cycle with noc=4 → next cycle all outputs 0 and IDLE; done never asserted.
  - start pulses while busy → ignored.
- **Back-to-back:** start held high continuously with mode=3, noc=1 → pattern of 1 store cycle followed by 1 idle cycle, repeating.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared constants and helpers for the memory-access sequencer.
package mem_seq_pkg;

    // Upper bound on the number of cores any instance may be built with.
    localparam int NUM_CORES_MAX = 16;

    // Transfer modes, latched with an accepted start.
    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_COMM  = 2'd1;
    localparam logic [1:0] MODE_DIFF  = 2'd2;
    localparam logic [1:0] MODE_STORE = 2'd3;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COMM  = 3'd1,
        ST_DIFF  = 3'd2,
        ST_STORE = 3'd3,
        ST_NULL  = 3'd4
    } state_e;

    // One-hot decode of a core index onto the widest possible core vector;
    // callers truncate to their own core count.
    function automatic logic [NUM_CORES_MAX-1:0] onehot16(input logic [3:0] i);
        logic [NUM_CORES_MAX-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_seq.sv
// Memory-access sequencer: drives AR/DR/D register strobes and the data-memory
// write strobe for broadcast load, per-core load and per-core store transfers.
// Outputs are registered copies of the decode of the next state, so they carry
// the same cycle timing as a Moore decode of the current state.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [15:0]          noc,
    output logic [NUM_CORES-1:0] ar_read_en,
    output logic [NUM_CORES-1:0] dr_wrt_en,
    output logic [NUM_CORES-1:0] d_read_en,
    output logic                 dmem_write,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PH_W  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int NOC_W = $clog2(NUM_CORES + 1);

    state_e             state_r,   state_nxt_s;
    logic [IDX_W-1:0]   idx_r,     idx_nxt_s;
    logic [PH_W-1:0]    ph_r,      ph_nxt_s;
    logic [NOC_W-1:0]   noc_eff_r, noc_nxt_s;

    logic [NOC_W-1:0]   noc_clamp_s;
    logic [NOC_W-1:0]   last_idx_s;
    logic [NOC_W-1:0]   last_idx_nxt_s;
    logic               ph_last_s;

    logic [NUM_CORES-1:0] onehot_nxt_s;
    logic [NUM_CORES-1:0] comm_mask_s;
    logic [NUM_CORES-1:0] ar_nxt_s;
    logic [NUM_CORES-1:0] dr_nxt_s;
    logic [NUM_CORES-1:0] d_nxt_s;
    logic                 dmem_nxt_s;
    logic                 busy_nxt_s;
    logic                 done_nxt_s;

    // Clamp the requested core count with a full-width unsigned compare.
    always_comb begin
        if (noc > 16'(NUM_CORES)) begin
            noc_clamp_s = NOC_W'(NUM_CORES);
        end else begin
            noc_clamp_s = noc[NOC_W-1:0];
        end
    end

    assign last_idx_s = noc_eff_r - NOC_W'(1);
    assign ph_last_s  = (ph_r == PH_W'(RD_LAT));

    // Next-state, core index, phase and latched core count.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        ph_nxt_s    = ph_r;
        noc_nxt_s   = noc_eff_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (mode != MODE_NONE)) begin
                    noc_nxt_s = noc_clamp_s;
                    idx_nxt_s = '0;
                    ph_nxt_s  = '0;
                    if (noc_clamp_s == '0) begin
                        state_nxt_s = ST_NULL;
                    end else begin
                        case (mode)
                            MODE_COMM:  state_nxt_s = ST_COMM;
                            MODE_DIFF:  state_nxt_s = ST_DIFF;
                            MODE_STORE: state_nxt_s = ST_STORE;
                            default:    state_nxt_s = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_NULL: begin
                state_nxt_s = ST_IDLE;
            end
            ST_COMM: begin
                if (ph_last_s) begin
                    state_nxt_s = ST_IDLE;
                    ph_nxt_s    = '0;
                end else begin
                    ph_nxt_s    = ph_r + PH_W'(1);
                end
            end
            ST_DIFF: begin
                if (ph_last_s) begin
                    ph_nxt_s = '0;
                    if (NOC_W'(idx_r) == last_idx_s) begin
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = '0;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    ph_nxt_s = ph_r + PH_W'(1);
                end
            end
            ST_STORE: begin
                if (NOC_W'(idx_r) == last_idx_s) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = '0;
                end else begin
                    idx_nxt_s   = idx_r + IDX_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = '0;
                ph_nxt_s    = '0;
            end
        endcase
    end

    assign last_idx_nxt_s = noc_nxt_s - NOC_W'(1);
    assign onehot_nxt_s   = NUM_CORES'(onehot16(4'(idx_nxt_s)));

    // Broadcast-load capture mask: every active core's data register.
    always_comb begin
        comm_mask_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            comm_mask_s[i] = (i < int'(noc_nxt_s));
        end
    end

    // Output decode of the state about to be entered.
    always_comb begin
        ar_nxt_s   = '0;
        dr_nxt_s   = '0;
        d_nxt_s    = '0;
        dmem_nxt_s = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_NULL: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            ST_COMM: begin
                busy_nxt_s = 1'b1;
                ar_nxt_s   = NUM_CORES'(1);
                if (ph_nxt_s == PH_W'(RD_LAT)) begin
                    dr_nxt_s   = comm_mask_s;
                    done_nxt_s = 1'b1;
                end else begin
                    dr_nxt_s   = '0;
                end
            end
            ST_DIFF: begin
                busy_nxt_s = 1'b1;
                ar_nxt_s   = onehot_nxt_s;
                if (ph_nxt_s == PH_W'(RD_LAT)) begin
                    dr_nxt_s   = onehot_nxt_s;
                    done_nxt_s = (NOC_W'(idx_nxt_s) == last_idx_nxt_s);
                end else begin
                    dr_nxt_s   = '0;
                end
            end
            ST_STORE: begin
                busy_nxt_s = 1'b1;
                ar_nxt_s   = onehot_nxt_s;
                d_nxt_s    = onehot_nxt_s;
                dmem_nxt_s = 1'b1;
                done_nxt_s = (NOC_W'(idx_nxt_s) == last_idx_nxt_s);
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            ph_r      <= '0;
            noc_eff_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            ph_r      <= ph_nxt_s;
            noc_eff_r <= noc_nxt_s;
        end
    end

    // Registered outputs; reset clears them in the same cycle as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_read_en <= '0;
            dr_wrt_en  <= '0;
            d_read_en  <= '0;
            dmem_write <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ar_read_en <= ar_nxt_s;
            dr_wrt_en  <= dr_nxt_s;
            d_read_en  <= d_nxt_s;
            dmem_write <= dmem_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq (NUM_CORES=4, RD_LAT=2): directed steps then
// random traffic, compared every cycle against a queue of expected cycles.
module tb_mem_seq;

    localparam int NC = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [15:0]   noc;
    logic [NC-1:0] ar_read_en;
    logic [NC-1:0] dr_wrt_en;
    logic [NC-1:0] d_read_en;
    logic          dmem_write;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          dmem;
        logic [NC-1:0] d;
        logic [NC-1:0] dr;
        logic [NC-1:0] ar;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    rec_t obs;
    int   checks = 0;
    int   errors = 0;

    mem_seq #(.NUM_CORES(NC), .RD_LAT(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .noc        (noc),
        .ar_read_en (ar_read_en),
        .dr_wrt_en  (dr_wrt_en),
        .d_read_en  (d_read_en),
        .dmem_write (dmem_write),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Append the per-cycle outputs of one accepted sequence to the queue.
    function automatic void gen(input logic [1:0] m, input logic [15:0] n);
        int   k;
        rec_t e;
        k = (n > 16'(NC)) ? NC : int'(n);
        if (k == 0) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1;
            exp_q.push_back(e);
        end else if (m == 2'd1) begin
            for (int p = 0; p <= RL; p++) begin
                e = '0; e.busy = 1'b1; e.ar = 4'b0001;
                if (p == RL) begin
                    e.dr = 4'((1 << k) - 1);
                    e.done = 1'b1;
                end
                exp_q.push_back(e);
            end
        end else if (m == 2'd2) begin
            for (int c = 0; c < k; c++) begin
                for (int p = 0; p <= RL; p++) begin
                    e = '0; e.busy = 1'b1; e.ar = 4'(1 << c);
                    if (p == RL) begin
                        e.dr = 4'(1 << c);
                        e.done = (c == k - 1);
                    end
                    exp_q.push_back(e);
                end
            end
        end else begin
            for (int c = 0; c < k; c++) begin
                e = '0; e.busy = 1'b1; e.dmem = 1'b1;
                e.ar = 4'(1 << c); e.d = 4'(1 << c);
                e.done = (c == k - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // One clock: drive inputs, update the model at the edge, compare after it.
    task automatic step(input logic s, input logic [1:0] m, input logic [15:0] n,
                        input logic r);
        start = s; mode = m; noc = n; rst = r;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else if (!cur.busy && s && (m != 2'd0)) begin
            gen(m, n);
        end
        #1;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
        obs.busy = busy; obs.done = done; obs.dmem = dmem_write;
        obs.d = d_read_en; obs.dr = dr_wrt_en; obs.ar = ar_read_en;
        checks++;
        assert (obs === cur) else begin
            errors++;
            $error("FAIL outputs t=%0t observed=%h expected=%h (busy,done,dmem,d,dr,ar)",
                   $time, obs, cur);
        end
    endtask

    initial begin
        int   r;
        logic [15:0] n;
        cur = '0;
        // reset state
        step(1'b0, 2'd0, 16'd0, 1'b1);
        step(1'b0, 2'd0, 16'd0, 1'b1);
        step(1'b0, 2'd0, 16'd0, 1'b0);
        // COMM noc=4
        step(1'b1, 2'd1, 16'd4, 1'b0);
        repeat (4) step(1'b0, 2'd1, 16'd4, 1'b0);
        // DIFF noc=2, noc changed mid-sequence
        step(1'b1, 2'd2, 16'd2, 1'b0);
        repeat (7) step(1'b0, 2'd2, 16'd4, 1'b0);
        // STORE noc=3
        step(1'b1, 2'd3, 16'd3, 1'b0);
        repeat (4) step(1'b0, 2'd3, 16'd3, 1'b0);
        // boundary core counts and ignored mode
        step(1'b1, 2'd2, 16'd0, 1'b0);
        repeat (2) step(1'b0, 2'd2, 16'd0, 1'b0);
        step(1'b1, 2'd3, 16'd9, 1'b0);
        repeat (5) step(1'b0, 2'd3, 16'd9, 1'b0);
        step(1'b1, 2'd3, 16'hFFFF, 1'b0);
        repeat (5) step(1'b0, 2'd0, 16'd0, 1'b0);
        step(1'b1, 2'd0, 16'd4, 1'b0);
        repeat (2) step(1'b0, 2'd0, 16'd4, 1'b0);
        // reset during the 4th DIFF cycle
        step(1'b1, 2'd2, 16'd4, 1'b0);
        repeat (3) step(1'b0, 2'd2, 16'd4, 1'b0);
        step(1'b1, 2'd1, 16'd4, 1'b1);
        repeat (3) step(1'b0, 2'd2, 16'd4, 1'b0);
        // start pulses while busy are ignored
        step(1'b1, 2'd2, 16'd4, 1'b0);
        for (int i = 0; i < 11; i++) step(i[0], 2'(1 + (i % 3)), 16'd1, 1'b0);
        repeat (2) step(1'b0, 2'd0, 16'd0, 1'b0);
        // back-to-back with start held high
        repeat (10) step(1'b1, 2'd3, 16'd1, 1'b0);
        step(1'b0, 2'd0, 16'd0, 1'b0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0:       n = 16'($urandom_range(0, 5));
                1:       n = 16'($urandom);
                2:       n = 16'hFFFF;
                default: n = 16'($urandom_range(1, 4));
            endcase
            step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), n,
                 ($urandom_range(0, 59) == 0));
        end
        repeat (20) step(1'b0, 2'd0, 16'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
